// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: producer-side character handshake into the transmitter FIFO
interface uart_tx_param_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data;
  logic data_valid;
  logic data_ready;
  modport master(output data, data_valid, input data_ready);
  modport slave(input data, data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with runtime character length, parity and stop bits
module uart_tx_param #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CTR_W = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1,
  localparam int CW = CTR_W + 1
) (
  input  logic clk,
  input  logic rst,
  uart_tx_param_if.slave host,
  input  logic [CTR_W-1:0] bit_duration,
  input  logic [3:0] data_bits,
  input  logic [1:0] parity_mode,
  input  logic [1:0] stopbits,
  output logic tx,
  output logic tx_busy,
  output logic tx_complete,
  output logic [LW-1:0] fifo_level
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level_n;
  logic push, pop, shift, done, done_q, tx_d, empty;
  logic [DATA_W-1:0] head, mask, sh;
  logic [3:0] db, f_bits, idx, idx_n;
  logic [CTR_W-1:0] bd, f_bd;
  logic [CW-1:0] cnt, cnt_n, bd_ext, stop_len;
  logic [1:0] f_stop;
  logic f_par, f_pbit;
  assign push = host.data_valid && host.data_ready;
  assign empty = fifo_level == '0;
  assign head = mem[rp];
  assign level_n = fifo_level + LW'(push) - LW'(pop);
  assign db = data_bits < 4'd5 ? 4'd5 : data_bits > 4'(DATA_W) ? 4'(DATA_W) : data_bits;
  assign mask = (DATA_W'(1) << db) - DATA_W'(1);
  assign bd = bit_duration < CTR_W'(2) ? CTR_W'(2) : bit_duration;
  assign bd_ext = {1'b0, f_bd};
  // one extra counter bit so a two-stop-bit duration of a full-scale bit_duration fits
  assign stop_len = f_stop == 2'b10 ? bd_ext << 1 : f_stop == 2'b11 ? bd_ext + (bd_ext >> 1) : bd_ext;
  assign tx_busy = state != IDLE || !empty;
  assign tx_d = state == START ? 1'b0 : state == DATA ? sh[0] : state == PARITY ? f_pbit : 1'b1;
  always_ff @(posedge clk)
    if (push) mem[wp] <= host.data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      host.data_ready <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      fifo_level <= level_n;
      host.data_ready <= level_n != LW'(FIFO_DEPTH);
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt - CW'(1);
    idx_n = idx;
    pop = 1'b0;
    shift = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (!empty) begin
          pop = 1'b1;
          state_n = START;
        end
      end
      START: if (cnt == '0) begin
        state_n = DATA;
        cnt_n = bd_ext - CW'(1);
        idx_n = f_bits - 4'd1;
      end
      DATA: if (cnt == '0) begin
        shift = 1'b1;
        idx_n = idx - 4'd1;
        cnt_n = (idx == '0 && !f_par ? stop_len : bd_ext) - CW'(1);
        if (idx == '0) state_n = f_par ? PARITY : STOP;
      end
      PARITY: if (cnt == '0) begin
        state_n = STOP;
        cnt_n = stop_len - CW'(1);
      end
      STOP: if (cnt == '0) begin
        done = 1'b1;
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  // tx and tx_complete lag the FSM by one stage so the pulse lands on the edge the stop bit ends
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      f_bits <= '0;
      f_bd <= '0;
      f_stop <= '0;
      f_par <= 1'b0;
      f_pbit <= 1'b0;
      tx <= 1'b1;
      done_q <= 1'b0;
      tx_complete <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      tx <= tx_d;
      done_q <= done;
      tx_complete <= done_q;
      cnt <= pop ? {1'b0, bd} - CW'(1) : cnt_n;
      if (pop) begin
        sh <= head & mask;
        f_bits <= db;
        f_bd <= bd;
        f_stop <= stopbits;
        f_par <= parity_mode == 2'b01 || parity_mode == 2'b10;
        f_pbit <= ^(head & mask) ^ (parity_mode == 2'b10);
      end else if (shift) sh <= sh >> 1;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: random and directed frames checked by a tx-line monitor against a queued frame model
module tb_uart_tx_param;
  typedef struct {
    int bd;
    int nw;
    int stop;
    logic [10:0] w;
    logic [7:0] d;
  } frame_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] bit_duration = 16'd10;
  logic [3:0] data_bits = 4'd8;
  logic [1:0] parity_mode = 2'd0;
  logic [1:0] stopbits = 2'd1;
  logic tx, tx_busy, tx_complete;
  logic [2:0] fifo_level;
  int total = 0;
  int bad = 0;
  int epoch = 0;
  int contig = 0;
  frame_t exp_q[$];
  uart_tx_param_if #(.DATA_W(8)) bus();
  uart_tx_param dut (
    .clk(clk), .rst(rst), .host(bus), .bit_duration(bit_duration), .data_bits(data_bits),
    .parity_mode(parity_mode), .stopbits(stopbits), .tx(tx), .tx_busy(tx_busy),
    .tx_complete(tx_complete), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  // expected frame as a list of bit levels plus a stop duration, built from the settings at push time
  function automatic frame_t mk(input logic [7:0] d);
    frame_t f;
    int nb, ones;
    f.bd = bit_duration < 16'd2 ? 2 : int'(bit_duration);
    nb = data_bits < 4'd5 ? 5 : data_bits > 4'd8 ? 8 : int'(data_bits);
    f.stop = stopbits == 2'd2 ? 2 * f.bd : stopbits == 2'd3 ? f.bd + f.bd / 2 : f.bd;
    f.d = d;
    f.w = '1;
    f.w[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      f.w[i+1] = d[i];
      ones += int'(d[i]);
    end
    f.nw = nb + 1;
    if (parity_mode == 2'd1 || parity_mode == 2'd2) begin
      f.w[f.nw] = ((ones % 2) == 1) ^ (parity_mode == 2'd2);
      f.nw++;
    end
    return f;
  endfunction
  function automatic logic lvl(input frame_t f, input int k);
    return k < f.nw * f.bd ? f.w[k / f.bd] : 1'b1;
  endfunction
  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  task automatic send(input logic [7:0] d);
    int w = 0;
    bus.data = d;
    bus.data_valid = 1'b1;
    while (!bus.data_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.data_ready) begin
      total++;
      bad++;
      $display("FAIL send timeout d=%h", d);
    end else exp_q.push_back(mk(d));
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int w = 0;
    while ((tx_busy || exp_q.size() != 0) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20000) begin
      total++;
      bad++;
      $display("FAIL idle timeout busy=%b queued=%0d", tx_busy, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_empty();
    int w = 0;
    while (fifo_level != 3'd0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) begin
      total++;
      bad++;
      $display("FAIL fifo drain timeout level=%0d", fifo_level);
    end
  endtask
  // monitor: follows the tx line sample by sample and checks each frame plus its completion pulse
  initial begin
    frame_t cur;
    int k, len, errs, fk, ep;
    logic act, ended, skip, fgot;
    act = 1'b0;
    skip = 1'b0;
    ep = 0;
    k = 0;
    len = 0;
    errs = 0;
    fk = 0;
    fgot = 1'b0;
    forever begin
      @(negedge clk);
      if (ep != epoch) begin
        ep = epoch;
        act = 1'b0;
        skip = 1'b0;
      end
      if (!rst) continue;
      ended = 1'b0;
      if (act && k == len) begin
        total++;
        if (tx_complete !== 1'b1) begin
          bad++;
          $display("FAIL complete d=%h got=%b want=1", cur.d, tx_complete);
        end
        act = 1'b0;
        ended = 1'b1;
      end else if (tx_complete !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL stray_complete got=%b want=0", tx_complete);
      end
      if (skip && tx === 1'b1) skip = 1'b0;
      if (!act && !skip && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          skip = 1'b1;
          $display("FAIL unexpected_start got=tx_low want=idle");
        end else begin
          cur = exp_q.pop_front();
          act = 1'b1;
          k = 0;
          len = cur.nw * cur.bd + cur.stop;
          errs = 0;
          if (ended) contig++;
        end
      end
      if (act) begin
        if (tx !== lvl(cur, k)) begin
          if (errs == 0) begin
            fk = k;
            fgot = tx;
          end
          errs++;
        end
        k++;
        if (k == len) begin
          total++;
          if (errs != 0) begin
            bad++;
            $display("FAIL frame d=%h bd=%0d errs=%0d first k=%0d got=%b want=%b", cur.d, cur.bd, errs, fk, fgot, lvl(cur, fk));
          end
        end
      end
    end
  end
  initial begin
    int c0, w;
    logic seen;
    bus.data = '0;
    bus.data_valid = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_ready", int'(bus.data_ready), 0);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_level", int'(fifo_level), 0);
    chk("reset_complete", int'(tx_complete), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(bus.data_ready), 1);
    // 8N1 at 868 clocks per bit, with start latency
    bit_duration = 16'd868;
    send(8'h72);
    @(negedge clk);
    chk("latency_n1", int'(tx), 1);
    @(negedge clk);
    chk("latency_n2", int'(tx), 0);
    wait_idle();
    // 7-bit even then odd parity
    bit_duration = 16'd10;
    data_bits = 4'd7;
    parity_mode = 2'd1;
    send(8'h55);
    wait_idle();
    parity_mode = 2'd2;
    send(8'h55);
    wait_idle();
    // stop bit lengths
    data_bits = 4'd8;
    parity_mode = 2'd0;
    stopbits = 2'd3;
    send(8'($urandom));
    wait_idle();
    stopbits = 2'd2;
    send(8'($urandom));
    wait_idle();
    stopbits = 2'd0;
    send(8'($urandom));
    wait_idle();
    // FIFO fill behind a busy transmitter
    bit_duration = 16'd4;
    stopbits = 2'd1;
    send(8'($urandom));
    wait_empty();
    c0 = contig;
    for (int i = 0; i < 4; i++) send(8'($urandom));
    chk("full_level", int'(fifo_level), 4);
    chk("full_ready", int'(bus.data_ready), 0);
    send(8'($urandom));
    wait_idle();
    chk("contiguous", contig - c0, 5);
    // reset in the middle of a frame with two queued
    bit_duration = 16'd10;
    send(8'hA5);
    send(8'h3C);
    send(8'hC3);
    repeat (45) @(negedge clk);
    chk("pre_reset_level", int'(fifo_level), 2);
    @(negedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    epoch++;
    #1;
    chk("abort_tx", int'(tx), 1);
    chk("abort_level", int'(fifo_level), 0);
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_ready", int'(bus.data_ready), 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | tx_complete | ~tx;
    end
    chk("abort_quiet", int'(seen), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", int'(bus.data_ready), 1);
    repeat (30) @(negedge clk);
    chk("abort_idle_busy", int'(tx_busy), 0);
    // settings changed mid-frame apply to the next frame only
    bit_duration = 16'd6;
    send(8'h96);
    wait_empty();
    repeat (10) @(negedge clk);
    parity_mode = 2'd2;
    data_bits = 4'd6;
    bit_duration = 16'd0;
    stopbits = 2'd3;
    send(8'hE7);
    wait_idle();
    // random batches of back-to-back characters
    for (int b = 0; b < 25; b++) begin
      bit_duration = 16'($urandom_range(0, 9));
      data_bits = 4'($urandom_range(0, 15));
      parity_mode = 2'($urandom_range(0, 3));
      stopbits = 2'($urandom_range(0, 3));
      w = $urandom_range(1, 5);
      for (int i = 0; i < w; i++) send(8'($urandom));
      wait_idle();
    end
    chk("leftover_frames", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
